ram_bist_ctrl: RTL and testbench

//  Initiator for the ram_single port (a/d/we/q, 128x8). Runs a 3-phase march test
//  ({W(P)} up, {R(P),W(~P)} up, {R(~P)} down) and reports pass/fail to the system.

---
 rtl/ram_bist_pkg.sv | 16 +
 rtl/ram_bist_addr_gen.sv | 43 ++++
 rtl/ram_bist_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM march-test controller: FSM states and default geometry.
package ram_bist_pkg;

  localparam int unsigned AddrWDefault = 7;
  localparam int unsigned DataWDefault = 8;
  localparam int unsigned ErrCntW      = 8;

  typedef enum logic [2:0] {
    StIdle,
    StW0,
    StR0W1,
    StR1,
    StFin
  } bist_state_e;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the march test; load takes priority over step.
module ram_bist_addr_gen
  import ram_bist_pkg::*;
#(
  parameter int unsigned AddrW = AddrWDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [AddrW-1:0] load_val_i,
  input  logic             step_i,
  input  logic             up_i,
  output logic [AddrW-1:0] addr_o,
  output logic             is_max_o,
  output logic             is_zero_o
);

  localparam logic [AddrW-1:0] AddrOne = AddrW'(1);

  logic [AddrW-1:0] addr_d, addr_q;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (step_i) begin
      addr_d = up_i ? addr_q + AddrOne : addr_q - AddrOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o    = addr_q;
  assign is_max_o  = &addr_q;
  assign is_zero_o = ~|addr_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-test initiator for a single-port RAM: {W(P)} up, {R(P),W(~P)} up, {R(~P)} down.
// Counts mismatches (saturating) and captures the first failing address and read data.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W       = AddrWDefault,
  parameter int unsigned DATA_W       = DataWDefault,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DATA_W-1:0]  pattern,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ErrCntW-1:0] err_cnt,
  output logic [ADDR_W-1:0]  fail_addr,
  output logic [DATA_W-1:0]  fail_data,
  output logic [ADDR_W-1:0]  mem_a,
  output logic [DATA_W-1:0]  mem_d,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_q
);

  bist_state_e        state_d, state_q;
  logic               c2_d, c2_q;
  logic [DATA_W-1:0]  pat_d, pat_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;
  logic               pass_d, pass_q;
  logic [ErrCntW-1:0] err_cnt_d, err_cnt_q;
  logic               fail_seen_d, fail_seen_q;
  logic [ADDR_W-1:0]  fail_addr_d, fail_addr_q;
  logic [DATA_W-1:0]  fail_data_d, fail_data_q;
  logic [DATA_W-1:0]  mem_d_d, mem_d_q;
  logic               mem_we_d, mem_we_q;

  logic               ag_load, ag_step, ag_up, ag_is_max, ag_is_zero;
  logic               cmp_en, mismatch;
  logic [DATA_W-1:0]  cmp_exp;

  ram_bist_addr_gen #(
    .AddrW(ADDR_W)
  ) u_addr_gen (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (ag_load),
    .load_val_i('0),
    .step_i    (ag_step),
    .up_i      (ag_up),
    .addr_o    (mem_a),
    .is_max_o  (ag_is_max),
    .is_zero_o (ag_is_zero)
  );

  always_comb begin
    state_d     = state_q;
    c2_d        = c2_q;
    pat_d       = pat_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    fail_seen_d = fail_seen_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    mem_d_d     = mem_d_q;
    mem_we_d    = mem_we_q;
    ag_load     = 1'b0;
    ag_step     = 1'b0;
    ag_up       = 1'b1;
    cmp_en      = 1'b0;
    cmp_exp     = pat_q;

    unique case (state_q)
      // FIN accepts start too, so a held start restarts with no idle gap.
      StIdle, StFin: begin
        if (start) begin
          pat_d       = pattern;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_cnt_d   = '0;
          fail_seen_d = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          mem_d_d     = pattern;
          mem_we_d    = 1'b1;
          ag_load     = 1'b1;
          c2_d        = 1'b0;
          state_d     = StW0;
        end else begin
          state_d = StIdle;
        end
      end
      StW0: begin
        if (ag_is_max) begin
          mem_we_d = 1'b0;
          ag_load  = 1'b1;
          state_d  = StR0W1;
        end else begin
          ag_step = 1'b1;
        end
      end
      StR0W1: begin
        c2_d = ~c2_q;
        if (!c2_q) begin
          mem_we_d = 1'b1;
          mem_d_d  = ~pat_q;
        end else begin
          cmp_en   = 1'b1;
          mem_we_d = 1'b0;
          if (ag_is_max) state_d = StR1;
          else           ag_step = 1'b1;
        end
      end
      StR1: begin
        c2_d  = ~c2_q;
        ag_up = 1'b0;
        if (c2_q) begin
          cmp_en  = 1'b1;
          cmp_exp = ~pat_q;
          if (ag_is_zero) state_d = StFin;
          else            ag_step = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Case inequality so an X on mem_q counts as a failure in simulation.
    mismatch = cmp_en && (mem_q !== cmp_exp);
    if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ErrCntW'(1);
      if (!fail_seen_q) begin
        fail_seen_d = 1'b1;
        fail_addr_d = mem_a;
        fail_data_d = mem_q;
      end
      if (STOP_ON_FAIL) begin
        state_d  = StFin;
        mem_we_d = 1'b0;
        ag_step  = 1'b0;
      end
    end

    if (busy_q && state_d == StFin) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pass_d = (err_cnt_d == '0);
      c2_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      c2_q        <= 1'b0;
      pat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_seen_q <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      mem_d_q     <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      c2_q        <= c2_d;
      pat_q       <= pat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fail_seen_q <= fail_seen_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      mem_d_q     <= mem_d_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign mem_d     = mem_d_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: two instances (run-to-end and stop-on-fail) each on its own RAM
// model with injectable stuck-at / X faults, checked against an abstract march-test model.
module tb_ram_bist_ctrl;

  localparam int Depth  = 128;
  localparam int RunCyc = 641;

  logic       clk, rst_n, start;
  logic [7:0] pattern;

  logic       busy_a, done_a, pass_a, we_a;
  logic [7:0] err_a, fd_a, d_a, q_a;
  logic [6:0] fa_a, a_a;
  logic       busy_b, done_b, pass_b, we_b;
  logic [7:0] err_b, fd_b, d_b, q_b;
  logic [6:0] fa_b, a_b;

  logic [7:0] ram_a [Depth];
  logic [7:0] ram_b [Depth];

  logic flt_en, flt_v, x_arm;
  int   flt_a, flt_b;
  int   n_tests, n_fail;

  ram_bist_ctrl #(.ADDR_W(7), .DATA_W(8), .STOP_ON_FAIL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .fail_addr(fa_a), .fail_data(fd_a),
    .mem_a(a_a), .mem_d(d_a), .mem_we(we_a), .mem_q(q_a)
  );

  ram_bist_ctrl #(.ADDR_W(7), .DATA_W(8), .STOP_ON_FAIL(1'b1)) dut_sof (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .fail_addr(fa_b), .fail_data(fd_b),
    .mem_a(a_b), .mem_d(d_b), .mem_we(we_b), .mem_q(q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stored value after a write, with an optional single stuck-at bit.
  function automatic logic [7:0] fwr(input int a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (flt_en && a == flt_a) r[flt_b] = flt_v;
    return r;
  endfunction

  always @(posedge clk) begin
    if (we_a) ram_a[a_a] <= fwr(int'(a_a), d_a);
    q_a <= (x_arm && a_a == 7'd0) ? 8'hxx : ram_a[a_a];
    if (we_b) ram_b[a_b] <= fwr(int'(a_b), d_b);
    q_b <= (x_arm && a_b == 7'd0) ? 8'hxx : ram_b[a_b];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Abstract march test on an array, then one DUT run compared against it.
  task automatic run_march(input string name, input logic [7:0] p, input bit xf);
    logic [7:0] m [Depth];
    logic [7:0] rd, first_d, fd_seen;
    int errs, first_a, stop_cyc, stop_b;
    int d0, d1, np0, np1, bb0, bb1;
    logic ps0, ps1;
    logic [7:0] er0, er1;
    logic [6:0] fa0, fa1;
    errs = 0; first_a = 0; first_d = 0; stop_cyc = RunCyc;
    d0 = 0; d1 = 0; np0 = 0; np1 = 0; bb0 = 0; bb1 = 0;
    ps0 = 0; ps1 = 0; er0 = 0; er1 = 0; fa0 = 0; fa1 = 0; fd_seen = 0;
    for (int a = 0; a < Depth; a++) m[a] = fwr(a, p);
    for (int a = 0; a < Depth; a++) begin
      rd = m[a];
      if (rd !== p) begin
        errs++;
        if (errs == 1) begin first_a = a; first_d = rd; stop_cyc = 128 + 2 * a + 3; end
      end
      m[a] = fwr(a, ~p);
    end
    for (int a = Depth - 1; a >= 0; a--) begin
      rd = (xf && a == 0) ? 8'hxx : m[a];
      if (rd !== ~p) begin
        errs++;
        if (errs == 1) begin
          first_a = a; first_d = rd; stop_cyc = 384 + 2 * (Depth - 1 - a) + 3;
        end
      end
    end
    stop_b = (errs > 0) ? stop_cyc : RunCyc;

    @(negedge clk);
    pattern = p;
    start   = 1'b1;
    x_arm   = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 300) x_arm = xf;
      if (busy_a !== (i < RunCyc)) bb0++;
      if (busy_b !== (i < stop_b)) bb1++;
      if (done_a === 1'b1) begin
        np0++;
        if (d0 == 0) begin d0 = i; ps0 = pass_a; er0 = err_a; fa0 = fa_a; fd_seen = fd_a; end
      end
      if (done_b === 1'b1) begin
        np1++;
        if (d1 == 0) begin d1 = i; ps1 = pass_b; er1 = err_b; fa1 = fa_b; end
      end
    end
    x_arm = 1'b0;

    check({name, ".done_cyc"}, d0, RunCyc);
    check({name, ".done_pulses"}, np0, 1);
    check({name, ".busy_shape"}, bb0, 0);
    check({name, ".pass"}, ps0, errs == 0);
    check({name, ".err_cnt"}, er0, errs);
    if (errs > 0) check({name, ".fail_addr"}, fa0, first_a);
    if (errs > 0 && !xf) check({name, ".fail_data"}, fd_seen, first_d);
    check({name, ".sof.done_cyc"}, d1, stop_b);
    check({name, ".sof.busy_shape"}, bb1, 0);
    check({name, ".sof.pass"}, ps1, errs == 0);
    check({name, ".sof.err_cnt"}, er1, (errs > 0) ? 1 : 0);
    if (errs > 0) check({name, ".sof.fail_addr"}, fa1, first_a);
  endtask

  initial begin
    int bad, nd;
    int dc_a[$], dc_b[$];
    logic pa_a[$], pa_b[$];
    logic [7:0] e2;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; pattern = 8'h00;
    flt_en = 1'b0; flt_v = 1'b0; flt_a = 0; flt_b = 0; x_arm = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_outputs_a", {busy_a, done_a, pass_a, err_a, fa_a, fd_a, a_a, d_a, we_a}, 64'd0);
    check("reset_outputs_b", {busy_b, done_b, pass_b, err_b, fa_b, fd_b, a_b, d_b, we_b}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_march("p55", 8'h55, 1'b0);
    bad = 0;
    for (int a = 0; a < Depth; a++) if (ram_a[a] !== 8'hAA) bad++;
    check("ram_all_aa", bad, 0);

    // Back-to-back tests with start held high through the first done.
    @(negedge clk);
    pattern = 8'h00;
    start   = 1'b1;
    e2      = 8'hEE;
    @(posedge clk);
    for (int i = 1; i <= 1300; i++) begin
      @(negedge clk);
      if (i == 1) pattern = 8'hFF;
      if (i == 642) start = 1'b0;
      if (done_a === 1'b1) begin dc_a.push_back(i); pa_a.push_back(pass_a); e2 = err_a; end
      if (done_b === 1'b1) begin dc_b.push_back(i); pa_b.push_back(pass_b); end
    end
    check("b2b.done_count_a", dc_a.size(), 2);
    check("b2b.done_count_b", dc_b.size(), 2);
    if (dc_a.size() == 2) begin
      check("b2b.first_done_a", dc_a[0], RunCyc);
      check("b2b.gap_a", dc_a[1] - dc_a[0], RunCyc);
      check("b2b.pass_a", {pa_a[0], pa_a[1]}, 2'b11);
      check("b2b.err_cnt_a", e2, 0);
    end
    if (dc_b.size() == 2) begin
      check("b2b.gap_b", dc_b[1] - dc_b[0], RunCyc);
      check("b2b.pass_b", {pa_b[0], pa_b[1]}, 2'b11);
    end

    // Bit 3 stuck at 0 at 0x2A.
    flt_en = 1'b1; flt_a = 'h2A; flt_b = 3; flt_v = 1'b0;
    run_march("stuck2a", 8'h08, 1'b0);
    flt_en = 1'b0;

    // Asynchronous reset in the middle of a test.
    nd = 0;
    @(negedge clk);
    pattern = 8'hC3;
    start   = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (done_a === 1'b1 || done_b === 1'b1) nd++;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_outputs_a", {busy_a, done_a, pass_a, err_a, fa_a, fd_a, a_a, d_a, we_a}, 64'd0);
    check("midrst_outputs_b", {busy_b, done_b, pass_b, err_b, fa_b, fd_b, a_b, d_b, we_b}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_a === 1'b1 || done_b === 1'b1) nd++;
    end
    check("midrst_no_done", nd, 0);
    rst_n = 1'b1;
    run_march("after_rst", 8'($urandom), 1'b0);

    // X on read data at address 0 during the descending read phase.
    run_march("x_addr0", 8'h5A, 1'b1);

    for (int k = 0; k < 4; k++) begin
      flt_en = 1'b1;
      flt_a  = $urandom_range(0, Depth - 1);
      flt_b  = $urandom_range(0, 7);
      flt_v  = 1'($urandom_range(0, 1));
      run_march($sformatf("rand%0d", k), 8'($urandom), 1'b0);
    end
    flt_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
